// File: rtl/core_io_pkg.sv
// -----------------------------------------------------------------------------
// core_io_pkg
// Shared definitions for the core I/O responder slice.
//
// Contents:
//   DEPTH_DEF / DATA_W_DEF / DB_CYCLES_DEF  default buffer depth, word width and
//                                           debounce stable-cycle count
//   state_t                                 responder phase enumeration
//   isResultPhase()                         true in the phases that drive Done
//
// No ports (package).
// -----------------------------------------------------------------------------
package core_io_pkg;

   localparam int DEPTH_DEF     = 16;
   localparam int DATA_W_DEF    = 8;
   localparam int DB_CYCLES_DEF = 16;

   // Responder phases:
   //   ST_COLLECT  - operator keys in the input words one press at a time
   //   ST_PROCESS  - the core drains inputs and writes results
   //   ST_PRESENT  - operator steps through results on the LEDs
   //   ST_FINISHED - nothing left to show, parked until reset
   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_PROCESS  = 2'd1,
      ST_PRESENT  = 2'd2,
      ST_FINISHED = 2'd3
   } state_t;

   // Done is raised in both result phases, so the FSM uses this to decide the
   // registered Done value together with the next state.
   function automatic logic isResultPhase(input state_t s);
      return (s == ST_PRESENT) || (s == ST_FINISHED);
   endfunction

endpackage

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Synchronous FIFO with occupancy count, full/empty flags and a registered
// read port. A combinational view of the head entry is also exported so the
// responder can show the next result on the LEDs without popping it.
//
// Parameters:
//   DEPTH   entries (power of two, at least 2)
//   DATA_W  word width
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset (pointers/count/valid only)
//   i_push       write request; ignored while full
//   i_pushData   word to write
//   i_pop        read request; ignored while empty
//   o_popData    popped word, valid the cycle after an accepted pop
//   o_popValid   high for one cycle after each accepted pop
//   o_head       current head entry (meaningful only when not empty)
//   o_count      occupancy, 0..DEPTH
//   o_full       count == DEPTH
//   o_empty      count == 0
// -----------------------------------------------------------------------------
module io_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_pushData,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_popData,
   output logic                     o_popValid,
   output logic [DATA_W-1:0]        o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_popData;
   logic              r_popValid;
   logic              w_doPush;
   logic              w_doPop;

   // Requests are qualified against the current flags so an overflowing write
   // or an underflowing read leaves every piece of state untouched.
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;

   // Storage carries no reset: stale words are unreachable once the pointers
   // and count are cleared, so only the bookkeeping needs resetting.
   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointer arithmetic relies on natural wrap of the AW-bit pointers. The
   // count only moves when exactly one of push/pop takes effect, so a
   // simultaneous push and pop keeps it steady while both pointers advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_popData  <= '0;
         r_popValid <= 1'b0;
      end else begin
         r_popValid <= w_doPop;
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr   <= r_rdPtr + AW'(1);
            r_popData <= r_mem[r_rdPtr];
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_popData  = r_popData;
   assign o_popValid = r_popValid;
   assign o_head     = r_mem[r_rdPtr];
   assign o_count    = r_count;

endmodule

// File: rtl/core_io_responder.sv
// -----------------------------------------------------------------------------
// core_io_responder
// Board-side I/O shell for a compute core. The operator keys DEPTH nibbles in
// on the switches (one per pushbutton press), the core reads them and writes
// its results, and after core_finish the operator steps through the results
// on the LEDs one press at a time.
//
// Optional build macro:
//   IO_DEBOUNCE_EN  when defined, the synchronized pushbutton must hold the
//                   same level for DB_CYCLES samples before the edge detector
//                   sees it. Undefined (default): edge detection works on the
//                   synchronized pushbutton directly.
//
// Parameters:
//   DEPTH      entries per buffer (power of two)
//   DATA_W     buffer word width
//   DB_CYCLES  debounce stable-cycle count (IO_DEBOUNCE_EN builds only)
//
// Ports:
//   Clock_pin    sole clock, rising edge
//   Reset_pin    asynchronous active-high reset
//   SW_pin       [4:1] data nibble, [0] pushbutton (asynchronous)
//   Display_pin  LED value
//   Done         result-presentation phase active
//   in_rd_req    core pops one input word
//   in_rd_data   popped input word
//   in_rd_valid  in_rd_data valid this cycle
//   in_empty     input buffer empty
//   out_wr_req   core pushes one result word
//   out_wr_data  result word
//   out_full     result buffer full
//   core_finish  core signals computation complete
// -----------------------------------------------------------------------------
module core_io_responder
   import core_io_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic              Clock_pin,
   input  logic              Reset_pin,
   input  logic [4:0]        SW_pin,
   output logic [7:0]        Display_pin,
   output logic              Done,
   input  logic              in_rd_req,
   output logic [DATA_W-1:0] in_rd_data,
   output logic              in_rd_valid,
   output logic              in_empty,
   input  logic              out_wr_req,
   input  logic [DATA_W-1:0] out_wr_data,
   output logic              out_full,
   input  logic              core_finish
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [4:0]        r_swSync1;
   logic [4:0]        r_swSync2;
   logic              w_btnLevel;
   logic              r_btnPrev;
   logic              w_press;

   state_t            r_state;
   logic              r_done;

   logic              w_inPush;
   logic              w_inPop;
   logic [DATA_W-1:0] w_inPushWord;
   logic [DATA_W-1:0] w_inHead;
   logic [CW-1:0]     w_inCount;
   logic              w_inFull;
   logic              w_inEmpty;

   logic              w_outPush;
   logic              w_outPop;
   logic              w_outLastPop;
   logic [DATA_W-1:0] w_outHead;
   logic [DATA_W-1:0] w_outPopData;
   logic              w_outPopValid;
   logic [CW-1:0]     w_outCount;
   logic              w_outFull;
   logic              w_outEmpty;

   // Two-flop synchronizer for the whole switch bank. The nibble and the
   // button travel together so the nibble pushed on a press is the one that
   // was on the switches when the button went down.
   always_ff @(posedge Clock_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_swSync1 <= '0;
         r_swSync2 <= '0;
      end else begin
         r_swSync1 <= SW_pin;
         r_swSync2 <= r_swSync1;
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int DBW = $clog2(DB_CYCLES + 1);

   logic           r_dbCand;
   logic           r_dbStable;
   logic [DBW-1:0] r_dbCnt;

   // Debounce: track how many consecutive samples have matched the current
   // candidate level; the stable level only follows once that run reaches
   // DB_CYCLES. Any differing sample restarts the run at one.
   always_ff @(posedge Clock_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_dbCand   <= 1'b0;
         r_dbStable <= 1'b0;
         r_dbCnt    <= '0;
      end else if (r_swSync2[0] != r_dbCand) begin
         r_dbCand <= r_swSync2[0];
         r_dbCnt  <= DBW'(1);
      end else begin
         if (r_dbCnt < DBW'(DB_CYCLES)) begin
            r_dbCnt <= r_dbCnt + DBW'(1);
         end
         if (r_dbCnt >= DBW'(DB_CYCLES - 1)) begin
            r_dbStable <= r_dbCand;
         end
      end
   end

   assign w_btnLevel = r_dbStable;
`else
   logic w_unusedDbCycles;

   assign w_btnLevel       = r_swSync2[0];
   assign w_unusedDbCycles = (DB_CYCLES < 1);
`endif

   // Rising-edge detector: one-cycle press pulse per button push.
   always_ff @(posedge Clock_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_btnPrev <= 1'b0;
      end else begin
         r_btnPrev <= w_btnLevel;
      end
   end

   assign w_press      = w_btnLevel & ~r_btnPrev;
   assign w_inPushWord = DATA_W'(r_swSync2[4:1]);

   // Buffer request qualification. Presses feed the input buffer only while
   // collecting and drain the result buffer only while presenting; the core
   // side is accepted in every phase.
   assign w_inPush  = w_press & (r_state == ST_COLLECT) & ~w_inFull;
   assign w_inPop   = in_rd_req & ~w_inEmpty;
   assign w_outPush = out_wr_req & ~w_outFull;
   assign w_outPop  = w_press & (r_state == ST_PRESENT) & ~w_outEmpty;

   // The presentation ends on the pop that actually leaves the result buffer
   // empty; a core write landing in the same cycle keeps one entry alive.
   assign w_outLastPop = w_outPop & ~w_outPush & (w_outCount == CW'(1));

   io_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_inFifo (
      .i_clk      (Clock_pin),
      .i_rst      (Reset_pin),
      .i_push     (w_inPush),
      .i_pushData (w_inPushWord),
      .i_pop      (w_inPop),
      .o_popData  (in_rd_data),
      .o_popValid (in_rd_valid),
      .o_head     (w_inHead),
      .o_count    (w_inCount),
      .o_full     (w_inFull),
      .o_empty    (w_inEmpty)
   );

   io_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_outFifo (
      .i_clk      (Clock_pin),
      .i_rst      (Reset_pin),
      .i_push     (w_outPush),
      .i_pushData (out_wr_data),
      .i_pop      (w_outPop),
      .o_popData  (w_outPopData),
      .o_popValid (w_outPopValid),
      .o_head     (w_outHead),
      .o_count    (w_outCount),
      .o_full     (w_outFull),
      .o_empty    (w_outEmpty)
   );

   // Phase sequencer. Done is registered alongside the state so it changes on
   // exactly the same edge as the phase it reflects.
   always_ff @(posedge Clock_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         r_state <= ST_COLLECT;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_inCount == CW'(DEPTH)) begin
                  r_state <= ST_PROCESS;
                  r_done  <= isResultPhase(ST_PROCESS);
               end
            end
            ST_PROCESS: begin
               if (core_finish) begin
                  r_state <= (w_outCount != '0) ? ST_PRESENT : ST_FINISHED;
                  r_done  <= 1'b1;
               end
            end
            ST_PRESENT: begin
               if (w_outLastPop) begin
                  r_state <= ST_FINISHED;
                  r_done  <= 1'b1;
               end
            end
            ST_FINISHED: begin
               r_state <= ST_FINISHED;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_COLLECT;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // LED source per phase: input fill level while collecting, result fill
   // level while processing, the head result while presenting, dark after.
   always_comb begin
      Display_pin = 8'h00;
      case (r_state)
         ST_COLLECT:  Display_pin = 8'(w_inCount);
         ST_PROCESS:  Display_pin = 8'(w_outCount);
         ST_PRESENT:  Display_pin = 8'(w_outHead);
         ST_FINISHED: Display_pin = 8'h00;
         default:     Display_pin = 8'h00;
      endcase
   end

   // The input head and the registered result read port have no consumer in
   // this shell; they are tied off here so the sharing of io_fifo stays clean.
   logic w_unusedFifoPorts;

   assign w_unusedFifoPorts = (^w_inHead) ^ (^w_outPopData) ^ w_outPopValid;

   assign Done     = r_done;
   assign in_empty = w_inEmpty;
   assign out_full = w_outFull;

endmodule

// File: tb/tb_core_io_responder.sv
// -----------------------------------------------------------------------------
// tb_core_io_responder
// Directed bench for core_io_responder with a queue-based reference model and
// a per-cycle compare process, plus hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_core_io_responder;

   localparam int DEPTH      = 16;
   localparam int M_COLLECT  = 0;
   localparam int M_PROCESS  = 1;
   localparam int M_PRESENT  = 2;
   localparam int M_FINISHED = 3;

   logic       Clock_pin;
   logic       Reset_pin;
   logic [4:0] SW_pin;
   logic [7:0] Display_pin;
   logic       Done;
   logic       in_rd_req;
   logic [7:0] in_rd_data;
   logic       in_rd_valid;
   logic       in_empty;
   logic       out_wr_req;
   logic [7:0] out_wr_data;
   logic       out_full;
   logic       core_finish;

   int compared   = 0;
   int mismatched = 0;

   core_io_responder dut (
      .Clock_pin   (Clock_pin),
      .Reset_pin   (Reset_pin),
      .SW_pin      (SW_pin),
      .Display_pin (Display_pin),
      .Done        (Done),
      .in_rd_req   (in_rd_req),
      .in_rd_data  (in_rd_data),
      .in_rd_valid (in_rd_valid),
      .in_empty    (in_empty),
      .out_wr_req  (out_wr_req),
      .out_wr_data (out_wr_data),
      .out_full    (out_full),
      .core_finish (core_finish)
   );

   initial Clock_pin = 1'b0;
   always #5 Clock_pin = ~Clock_pin;

   // One comparison: counts it, reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: what the responder must hold after each edge.
   int         mMode;
   logic [7:0] inQ[$];
   logic [7:0] outQ[$];
   logic [4:0] h1, h2, h3;
   logic       expValid;
   logic [7:0] expData;
   int         mInN, mOutN;
   bit         mPress, mOutPush, mOutPop;
   logic [3:0] mNib;
   logic [7:0] mDisp;

   // Pin history: a press is consumed on the third edge after the pin is
   // first seen high, with the nibble seen alongside it.
   always @(posedge Clock_pin or posedge Reset_pin) begin
      if (Reset_pin) begin
         mMode    = M_COLLECT;
         inQ.delete();
         outQ.delete();
         h1       = '0;
         h2       = '0;
         h3       = '0;
         expValid = 1'b0;
         expData  = '0;
      end else begin
         mInN   = inQ.size();
         mOutN  = outQ.size();
         mPress = h2[0] && !h3[0];
         mNib   = h2[4:1];
         h3 = h2;
         h2 = h1;
         h1 = SW_pin;
         if (in_rd_req && mInN > 0) begin
            expValid = 1'b1;
            expData  = inQ.pop_front();
         end else begin
            expValid = 1'b0;
         end
         if (mMode == M_COLLECT && mPress && mInN < DEPTH)
            inQ.push_back({4'h0, mNib});
         mOutPush = out_wr_req && (mOutN < DEPTH);
         mOutPop  = (mMode == M_PRESENT) && mPress && (mOutN > 0);
         if (mOutPop) void'(outQ.pop_front());
         if (mOutPush) outQ.push_back(out_wr_data);
         case (mMode)
            M_COLLECT: if (mInN == DEPTH) mMode = M_PROCESS;
            M_PROCESS: if (core_finish) mMode = (mOutN > 0) ? M_PRESENT : M_FINISHED;
            M_PRESENT: if (mOutPop && !mOutPush && mOutN == 1) mMode = M_FINISHED;
            default:   mMode = mMode;
         endcase
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge Clock_pin) begin
      if (!Reset_pin) begin
         case (mMode)
            M_COLLECT: mDisp = 8'(inQ.size());
            M_PROCESS: mDisp = 8'(outQ.size());
            M_PRESENT: mDisp = (outQ.size() > 0) ? outQ[0] : 8'h00;
            default:   mDisp = 8'h00;
         endcase
         checkOutput("model_display", Display_pin, mDisp);
         checkOutput("model_done", Done, (mMode == M_PRESENT || mMode == M_FINISHED));
         checkOutput("model_in_empty", in_empty, (inQ.size() == 0));
         checkOutput("model_out_full", out_full, (outQ.size() == DEPTH));
         checkOutput("model_rd_valid", in_rd_valid, expValid);
         if (expValid) checkOutput("model_rd_data", in_rd_data, expData);
      end
   end

   // One pushbutton press carrying a nibble; called right after a negedge.
   task automatic applyStimulus(input logic [3:0] nib);
      SW_pin = {nib, 1'b1};
      repeat (4) @(negedge Clock_pin);
      SW_pin = {nib, 1'b0};
      repeat (4) @(negedge Clock_pin);
   endtask

   task automatic doReset();
      Reset_pin   = 1'b1;
      SW_pin      = '0;
      in_rd_req   = 1'b0;
      out_wr_req  = 1'b0;
      out_wr_data = '0;
      core_finish = 1'b0;
      repeat (2) @(negedge Clock_pin);
      Reset_pin = 1'b0;
   endtask

   task automatic collectAll(input bit checkCounts);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(4'(i + 1));
         if (checkCounts && i < DEPTH - 1)
            checkOutput("collect_count", Display_pin, i + 1);
      end
   endtask

   initial begin
      Reset_pin   = 1'b1;
      SW_pin      = '0;
      in_rd_req   = 1'b0;
      out_wr_req  = 1'b0;
      out_wr_data = '0;
      core_finish = 1'b0;
      repeat (2) @(negedge Clock_pin);
      checkOutput("rst_display", Display_pin, 8'h00);
      checkOutput("rst_done", Done, 1'b0);
      checkOutput("rst_in_empty", in_empty, 1'b1);
      checkOutput("rst_out_full", out_full, 1'b0);
      checkOutput("rst_rd_valid", in_rd_valid, 1'b0);
      Reset_pin = 1'b0;
      @(negedge Clock_pin);

      $display("[TB] collecting 16 nibbles");
      collectAll(1'b1);
      checkOutput("process_display", Display_pin, 8'h00);
      checkOutput("process_in_empty", in_empty, 1'b0);
      checkOutput("process_done", Done, 1'b0);

      $display("[TB] draining input buffer");
      for (int i = 0; i <= DEPTH; i++) begin
         in_rd_req = 1'b1;
         @(negedge Clock_pin);
         if (i < DEPTH) begin
            checkOutput("rd_valid", in_rd_valid, 1'b1);
            checkOutput("rd_data", in_rd_data, 8'((i + 1) % 16));
         end else begin
            checkOutput("rd_empty_valid", in_rd_valid, 1'b0);
         end
      end
      in_rd_req = 1'b0;

      $display("[TB] writing results");
      for (int i = 0; i <= DEPTH; i++) begin
         out_wr_req  = 1'b1;
         out_wr_data = (i < DEPTH) ? 8'(8'hA0 + i) : 8'hFF;
         @(negedge Clock_pin);
      end
      out_wr_req = 1'b0;
      checkOutput("wr_out_full", out_full, 1'b1);
      checkOutput("wr_result_count", Display_pin, 8'h10);
      core_finish = 1'b1;
      @(negedge Clock_pin);
      core_finish = 1'b0;
      checkOutput("present_done", Done, 1'b1);
      checkOutput("present_head", Display_pin, 8'hA0);

      $display("[TB] stepping through results");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(4'h0);
         if (i < DEPTH - 1) begin
            checkOutput("present_step", Display_pin, 8'(8'hA1 + i));
         end else begin
            checkOutput("finished_display", Display_pin, 8'h00);
            checkOutput("finished_done", Done, 1'b1);
         end
      end

      $display("[TB] finish with no results");
      doReset();
      collectAll(1'b0);
      core_finish = 1'b1;
      @(negedge Clock_pin);
      core_finish = 1'b0;
      checkOutput("empty_finish_done", Done, 1'b1);
      checkOutput("empty_finish_display", Display_pin, 8'h00);

      $display("[TB] asynchronous reset mid-process");
      doReset();
      collectAll(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         out_wr_req  = 1'b1;
         out_wr_data = 8'(8'h30 + i);
         @(negedge Clock_pin);
      end
      out_wr_req = 1'b0;
      checkOutput("pre_rst_out_full", out_full, 1'b1);
      in_rd_req = 1'b1;
      @(posedge Clock_pin);
      #3;
      Reset_pin = 1'b1;
      #1;
      checkOutput("async_rst_display", Display_pin, 8'h00);
      checkOutput("async_rst_done", Done, 1'b0);
      checkOutput("async_rst_in_empty", in_empty, 1'b1);
      checkOutput("async_rst_rd_valid", in_rd_valid, 1'b0);
      checkOutput("async_rst_out_full", out_full, 1'b0);
      in_rd_req = 1'b0;
      repeat (2) @(negedge Clock_pin);
      Reset_pin = 1'b0;
      repeat (2) @(negedge Clock_pin);
      checkOutput("post_rst_display", Display_pin, 8'h00);
      checkOutput("post_rst_in_empty", in_empty, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: run did not complete, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/core_io_responder.md
CORE_IO_RESPONDER -- requirements
Module: core_io_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per buffer (power of two).
REQ-002 SHALL have parameter DATA_W, default 8, buffer word width.
REQ-003 SHALL have parameter DB_CYCLES, default 16, debounce stable-cycle count (used only with IO_DEBOUNCE_EN).
REQ-004 SHALL have port Clock_pin  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_pin  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SW_pin  input  5  [4:1] data nibble, [0] pushbutton step (asynchronous to Clock_pin).
REQ-007 SHALL have port Display_pin  output  8  LED value.
REQ-008 SHALL have port Done  output  1  result-presentation phase active.
REQ-009 SHALL have port in_rd_req  input  1  core pops one input word.
REQ-010 SHALL have port in_rd_data  output  DATA_W  popped input word.
REQ-011 SHALL have port in_rd_valid  output  1  in_rd_data valid this cycle.
REQ-012 SHALL have port in_empty  output  1  input buffer empty.
REQ-013 SHALL have port out_wr_req  input  1  core pushes one result word.
REQ-014 SHALL have port out_wr_data  input  DATA_W  result word.
REQ-015 SHALL have port out_full  output  1  result buffer full.
REQ-016 SHALL have port core_finish  input  1  core signals computation complete.

Function
REQ-017 SHALL synchronize SW_pin through 2 flops and form a one-cycle press pulse on the 0->1 edge of synchronized SW_pin[0].
REQ-018 SHALL implement states COLLECT, PROCESS, PRESENT, FINISHED.
REQ-019 COLLECT: each press SHALL push {0, SW_pin[4:1]} (synchronized nibble, zero-extended) into the input buffer; Display_pin = input count; Done=0.
REQ-020 COLLECT SHALL move to PROCESS in the cycle after the push that makes the input count equal DEPTH.
REQ-021 PROCESS: presses SHALL be ignored; Display_pin = result count; Done=0.
REQ-022 in_rd_req when not in_empty SHALL pop, with in_rd_data/in_rd_valid asserted exactly one cycle later; in_rd_req while empty SHALL be ignored (in_rd_valid=0).
REQ-023 out_wr_req when not out_full SHALL push out_wr_data; a write while full SHALL be dropped with no state change.
REQ-024 Reads and writes SHALL be accepted in any state; in_rd_req in COLLECT is legal.
REQ-025 core_finish in PROCESS SHALL move to PRESENT if result count >0, else FINISHED; core_finish in other states SHALL be ignored.
REQ-026 PRESENT: Done=1; Display_pin = result-buffer head; each press pops one entry; the pop emptying the buffer SHALL move to FINISHED.
REQ-027 FINISHED: Done=1, Display_pin=8'h00; held until reset.
REQ-028 Buffer pointers SHALL wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits.
REQ-029 A simultaneous push and pop on one buffer SHALL leave its count unchanged and both take effect.

Reset
REQ-030 Reset_pin high SHALL immediately force: state COLLECT, both buffers empty, Display_pin=0, Done=0, in_rd_valid=0, in_empty=1, out_full=0, sync/edge flops 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered data; buffer RAM contents need not clear.

Configuration
REQ-032 With IO_DEBOUNCE_EN defined, synchronized SW_pin[0] SHALL be accepted only after DB_CYCLES consecutive equal samples before edge detection.
REQ-033 Without IO_DEBOUNCE_EN, edge detection SHALL act on synchronized SW_pin[0] directly (press visible 3 cycles after pin rise).

Structure
REQ-034 Package core_io_pkg SHALL hold the state enum and DEPTH/DATA_W defaults.
REQ-035 Sub-module io_fifo (sync FIFO, count, full/empty, registered read) SHALL be instantiated twice: input and result buffers.

Verification
REQ-036 16 presses with SW_pin[4:1]=1..16 (mod 16) -> Display 1..16 in COLLECT, PROCESS entered, in_empty=0.
REQ-037 16 in_rd_req in PROCESS -> in_rd_data 8'h01..8'h0F,8'h00 each one cycle after req; 17th req -> in_rd_valid=0.
REQ-038 Write 8'hA0..8'hAF then 17th write 8'hFF, core_finish -> out_full=1, 8'hFF dropped, Done=1, Display=8'hA0.
REQ-039 16 presses in PRESENT -> Display steps 8'hA1..8'hAF, then 8'h00 with Done=1 (FINISHED).
REQ-040 core_finish with zero results -> FINISHED directly, Display=8'h00.
REQ-041 Reset_pin pulse mid-PROCESS, asynchronous to clock -> outputs at reset values before next edge, in_empty=1.
